// File: rtl/rr_sel_pkg.sv
// Shared types and constants for the 4-channel round-robin select arbiter.
package rr_sel_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [0:0] {IDLE, GRANT} state_t;
    typedef logic [NUM_CH-1:0] chvec_t;

    function automatic chvec_t onehot(input logic [SEL_W-1:0] idx);
        return chvec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority search: first set req bit after 'last', wrapping 3->0.
import rr_sel_pkg::*;

module rr_pick4 (
    input  chvec_t           req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] win
);

    logic [SEL_W-1:0] idx;

    // Scan farthest-to-nearest so the channel closest after 'last' overwrites the others.
    always_comb begin
        any = 1'b0;
        win = last;
        idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last + SEL_W'(i);
            if (req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select, with one dead cycle between owners.
// Optional forced release after MAX_HOLD grant cycles when RR_SEL_TIMEOUT_EN is defined.
import rr_sel_pkg::*;

module rr_sel_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  chvec_t           req,
    output chvec_t           gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid
);

    state_t           state_q, state_d;
    chvec_t           gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic             pick_any;
    logic [SEL_W-1:0] pick_win;
    logic             timeout;
    logic             release_now;

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("rr_sel_arbiter: MAX_HOLD must be >= 2");
    end

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .win  (pick_win)
    );

`ifdef RR_SEL_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter reads 0 on the first GRANT cycle, so the owner keeps gnt for MAX_HOLD cycles.
    always_comb cnt_d = (state_q == GRANT) ? cnt_q + CNT_W'(1) : '0;
    assign timeout = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign release_now = !req[sel_q] || timeout;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = onehot(pick_win);
                    sel_d   = pick_win;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    last_d  = sel_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last resets to 3 so the first search after reset starts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= SEL_W'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule
